// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM sequencer.
// State and trigger-source encodings, block size.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        NEXT
    } bk_state_t;

    typedef enum logic [1:0] {
        SRC_DL,
        SRC_LOAD,
        SRC_SAVE,
        SRC_AUTO
    } bk_src_t;

    localparam int BLK_SHIFT = 9;

    function automatic logic src_is_load(bk_src_t s);
        return (s == SRC_DL) || (s == SRC_LOAD);
    endfunction

endpackage

// File: rtl/bk_timer.sv
// Load/enable cycle timer: expire pulses on the CYCLES-th
// enabled cycle after the last load, then restarts.
module bk_timer #(
    parameter int CYCLES = 100
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(CYCLES) + 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    assign expire = en & ~load & (cnt == LAST);

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bk_ram_sequencer.sv
// Backup-RAM transfer sequencer between the dual-port BSRAM and the
// HPS SD block interface: boot load, OSD load/save, timed autosave.
module bk_ram_sequencer #(
    parameter int AUTOSAVE_CYCLES = 64_000_000,
    parameter int ACK_TIMEOUT     = 2_000_000,
    parameter int LBA_BITS        = 15
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_nz,
    input  logic        bk_load_req,
    input  logic        bk_save_req,
    input  logic        autosave_en,
    input  logic        bsram_we,
    input  logic [23:0] ram_mask,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        bk_busy,
    output logic        bk_dirty,
    output logic        bk_err
);

    import bk_pkg::*;

    bk_state_t           state;
    logic [LBA_BITS-1:0] lba;
    logic [LBA_BITS-1:0] last;
    logic                dl_q, ld_q, sv_q, ack_q;
    logic                ld_lvl, sv_lvl;
    logic                dl_rise, dl_fall;
    logic                ld_edge, sv_edge;
    logic                ack_rise, ack_fall;
    logic                auto_fire, tmo;
    logic                tmo_load, tmo_en;
    logic                auto_load, auto_en;
    logic                trig, is_load;
    logic                start, done;
    bk_src_t             src;
    logic                unused_mask;

    assign unused_mask = ^ram_mask[BLK_SHIFT-1:0];
    assign last        = ram_mask[BLK_SHIFT +: LBA_BITS];
    assign sd_lba      = {{(32 - LBA_BITS){1'b0}}, lba};
    assign bk_busy     = (state != IDLE);

    assign ld_lvl   = bk_load_req & bk_ena;
    assign sv_lvl   = bk_save_req & bk_ena;
    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign ld_edge  = ld_lvl & ~ld_q;
    assign sv_edge  = sv_lvl & ~sv_q;
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;

    assign trig = (dl_fall & bk_ena) | ld_edge | sv_edge | auto_fire;

    always_comb begin
        src = SRC_AUTO;
        if (dl_fall && bk_ena) begin
            src = SRC_DL;
        end else if (ld_edge) begin
            src = SRC_LOAD;
        end else if (sv_edge) begin
            src = SRC_SAVE;
        end
    end

    assign is_load = src_is_load(src);
    assign start   = (state == IDLE) & trig & ~dl_rise;
    assign done    = (state == NEXT) & (lba >= last) & ~dl_rise;

    // Ack timer restarts on every state change and runs only while waiting.
    assign tmo_en   = (state == REQ) | (state == ACK);
    assign tmo_load = ~tmo_en | ((state == REQ) & ack_rise);

    assign auto_load = bsram_we | ~autosave_en;
    assign auto_en   = bk_dirty & autosave_en & bk_ena & ~bk_busy;

    bk_timer #(
        .CYCLES (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (tmo_load),
        .en      (tmo_en),
        .expire  (tmo)
    );

    bk_timer #(
        .CYCLES (AUTOSAVE_CYCLES)
    ) u_auto_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (auto_load),
        .en      (auto_en),
        .expire  (auto_fire)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            dl_q  <= 1'b0;
            ld_q  <= 1'b0;
            sv_q  <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            dl_q  <= ioctl_download;
            ld_q  <= ld_lvl;
            sv_q  <= sv_lvl;
            ack_q <= sd_ack;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            bk_ena <= 1'b0;
        end else begin
            if (dl_rise) begin
                bk_ena <= 1'b0;
            end
            if (ioctl_download && img_mounted &&
                img_size_nz && !img_readonly) begin
                bk_ena <= 1'b1;
            end
        end
    end

    // A write in the same cycle as a save start still marks dirty.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            bk_dirty <= 1'b0;
        end else begin
            if ((start && !is_load) || (done && bk_loading)) begin
                bk_dirty <= 1'b0;
            end
            if (bsram_we && !bk_loading) begin
                bk_dirty <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state      <= IDLE;
            lba        <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            bk_err     <= 1'b0;
        end else if (dl_rise) begin
            state      <= IDLE;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        lba        <= '0;
                        bk_loading <= is_load;
                        sd_rd      <= is_load;
                        sd_wr      <= ~is_load;
                        bk_err     <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= ACK;
                    end else if (tmo) begin
                        sd_rd      <= 1'b0;
                        sd_wr      <= 1'b0;
                        bk_loading <= 1'b0;
                        bk_err     <= 1'b1;
                        state      <= IDLE;
                    end
                end
                ACK: begin
                    if (ack_fall) begin
                        state <= NEXT;
                    end else if (tmo) begin
                        bk_loading <= 1'b0;
                        bk_err     <= 1'b1;
                        state      <= IDLE;
                    end
                end
                NEXT: begin
                    if (lba >= last) begin
                        bk_loading <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lba   <= lba + 1'b1;
                        sd_rd <= bk_loading;
                        sd_wr <= ~bk_loading;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_ram_sequencer.sv
// Self-checking bench for bk_ram_sequencer: vector table,
// randomized transfers against a block-list model, corner sequences.
module tb_bk_ram_sequencer;

    localparam int AUTOSAVE = 100;
    localparam int ACK_TMO  = 20;
    localparam int OP_DL    = 0;
    localparam int OP_LOAD  = 1;
    localparam int OP_SAVE  = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, img_mounted, img_readonly, img_size_nz;
    logic        bk_load_req, bk_save_req, autosave_en, bsram_we;
    logic [23:0] ram_mask;
    logic        sd_ack, resp_ack, man_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err;

    int checks = 0;
    int errors = 0;
    bit resp_en = 1'b0;
    int dly_max = 3;
    int log_lba[$];
    bit log_rd[$];
    bit log_wr[$];
    bit log_ld[$];

    typedef struct {
        int          op;
        logic [23:0] mask;
        int          exp_n;
    } vec_t;

    vec_t vecs[6];

    assign sd_ack = resp_ack | man_ack;

    always #5 clk_sys = ~clk_sys;

    bk_ram_sequencer #(
        .AUTOSAVE_CYCLES (AUTOSAVE),
        .ACK_TIMEOUT     (ACK_TMO),
        .LBA_BITS        (15)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .img_mounted    (img_mounted),
        .img_readonly   (img_readonly),
        .img_size_nz    (img_size_nz),
        .bk_load_req    (bk_load_req),
        .bk_save_req    (bk_save_req),
        .autosave_en    (autosave_en),
        .bsram_we       (bsram_we),
        .ram_mask       (ram_mask),
        .sd_ack         (sd_ack),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .bk_ena         (bk_ena),
        .bk_loading     (bk_loading),
        .bk_busy        (bk_busy),
        .bk_dirty       (bk_dirty),
        .bk_err         (bk_err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: blocks 0..ram_mask[23:9], one per 512 bytes.
    function automatic int model_blocks(input logic [23:0] mask);
        return int'(mask >> 9) + 1;
    endfunction

    // HPS side: log each request, ack after a random delay.
    initial begin
        resp_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (resp_en && (sd_rd || sd_wr)) begin
                log_lba.push_back(int'(sd_lba));
                log_rd.push_back(sd_rd);
                log_wr.push_back(sd_wr);
                log_ld.push_back(bk_loading);
                repeat ($urandom_range(0, dly_max)) @(negedge clk_sys);
                resp_ack = 1'b1;
                @(negedge clk_sys);
                check($sformatf("req drop lba %0d", sd_lba),
                      int'({sd_rd, sd_wr}), 0);
                repeat ($urandom_range(0, 2)) @(negedge clk_sys);
                resp_ack = 1'b0;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log();
        log_lba.delete();
        log_rd.delete();
        log_wr.delete();
        log_ld.delete();
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (bk_busy && c < 3000) begin
            @(negedge clk_sys);
            c++;
        end
        check({tag, " idle"}, int'(bk_busy), 0);
    endtask

    task automatic mount();
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        img_mounted  = 1'b1;
        img_size_nz  = 1'b1;
        img_readonly = 1'b0;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        check("bk_ena after mount", int'(bk_ena), 1);
    endtask

    task automatic trigger(input int op);
        if (op == OP_DL) begin
            mount();
            ioctl_download = 1'b0;
        end else if (op == OP_LOAD) begin
            bk_load_req = 1'b1;
        end else begin
            bk_save_req = 1'b1;
        end
        @(negedge clk_sys);
        bk_load_req = 1'b0;
        bk_save_req = 1'b0;
    endtask

    task automatic verify_log(input string tag, input logic [23:0] mask,
                              input bit ld, input int exp_n);
        int n = model_blocks(mask);
        check({tag, " blocks"}, log_lba.size(), exp_n);
        for (int i = 0; i < n && i < log_lba.size(); i++) begin
            check($sformatf("%s lba[%0d]", tag, i), log_lba[i], i);
            check($sformatf("%s rd/wr/ld[%0d]", tag, i),
                  int'({log_rd[i], log_wr[i], log_ld[i]}),
                  int'({ld, ~ld, ld}));
        end
        check({tag, " loading end"}, int'(bk_loading), 0);
        check({tag, " err"}, int'(bk_err), 0);
        if (ld) begin
            check({tag, " dirty"}, int'(bk_dirty), 0);
        end
    endtask

    task automatic run_op(input string tag, input int op,
                          input logic [23:0] mask, input int exp_n);
        ram_mask = mask;
        clear_log();
        trigger(op);
        wait_idle(tag);
        verify_log(tag, mask, op != OP_SAVE, exp_n);
    endtask

    task automatic wait_wr(input int budget, output int first);
        first = -1;
        for (int c = 0; c < budget && first < 0; c++) begin
            @(negedge clk_sys);
            if (sd_wr) first = c;
        end
    endtask

    // Writes at cycle 0 and w2; save expected AUTOSAVE after the last one.
    task automatic autosave_case(input int w2);
        int first = -1;
        int last_w = (w2 > 0) ? w2 : 0;
        ram_mask    = 24'h3FF;
        autosave_en = 1'b1;
        clear_log();
        for (int c = 0; c < 400 && first < 0; c++) begin
            bsram_we = (c == 0) || (c == w2);
            @(negedge clk_sys);
            bsram_we = 1'b0;
            if (c == 0) check("dirty after write", int'(bk_dirty), 1);
            if (sd_wr) first = c;
        end
        check($sformatf("autosave cycle w2=%0d", w2), first, last_w + AUTOSAVE);
        check("dirty cleared at save", int'(bk_dirty), 0);
        wait_idle("autosave");
        verify_log("autosave", 24'h3FF, 1'b0, model_blocks(24'h3FF));
    endtask

    task automatic wait_wr_lba(input int lba, output bit ok);
        int c = 0;
        while (!(sd_wr && sd_lba == 32'(lba)) && c < 100) begin
            @(negedge clk_sys);
            c++;
        end
        ok = sd_wr && (sd_lba == 32'(lba));
    endtask

    initial begin
        int  first;
        int  seen;
        bit  ok;

        vecs[0] = '{OP_DL,   24'h1FFF, 16};
        vecs[1] = '{OP_SAVE, 24'h07FF, 4};
        vecs[2] = '{OP_LOAD, 24'h01FF, 1};
        vecs[3] = '{OP_SAVE, 24'h0000, 1};
        vecs[4] = '{OP_LOAD, 24'h03FF, 2};
        vecs[5] = '{OP_SAVE, 24'h05FF, 3};

        reset          = 1'b0;
        ioctl_download = 1'b0;
        img_mounted    = 1'b0;
        img_readonly   = 1'b0;
        img_size_nz    = 1'b0;
        bk_load_req    = 1'b0;
        bk_save_req    = 1'b0;
        autosave_en    = 1'b0;
        bsram_we       = 1'b0;
        ram_mask       = 24'h0;
        man_ack        = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset outputs",
              int'({sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err}), 0);
        check("reset lba", int'(sd_lba), 0);
        reset = 1'b1;
        @(negedge clk_sys);
        resp_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].mask, vecs[i].exp_n);
        end

        // Download end and save request together: load wins, save dropped.
        ram_mask = 24'h1FFF;
        clear_log();
        mount();
        ioctl_download = 1'b0;
        bk_save_req    = 1'b1;
        @(negedge clk_sys);
        wait_idle("dl+save");
        verify_log("dl+save", 24'h1FFF, 1'b1, 16);
        repeat (30) @(negedge clk_sys);
        check("save dropped busy", int'(bk_busy), 0);
        check("save dropped log", log_lba.size(), 16);
        bk_save_req = 1'b0;
        @(negedge clk_sys);

        autosave_case(-1);
        autosave_case(50);
        autosave_case($urandom_range(1, 99));

        // Write during save re-dirties; disabled autosave never fires.
        bsram_we = 1'b1;
        @(negedge clk_sys);
        bsram_we = 1'b0;
        wait_wr(300, first);
        check("autosave started", int'(first >= 0), 1);
        bsram_we    = 1'b1;
        autosave_en = 1'b0;
        @(negedge clk_sys);
        bsram_we = 1'b0;
        wait_idle("redirty");
        check("dirty after write in save", int'(bk_dirty), 1);
        seen = 0;
        repeat (300) begin
            @(negedge clk_sys);
            if (bk_busy) seen++;
        end
        check("no save while disabled", seen, 0);
        autosave_en = 1'b1;
        wait_wr(300, first);
        check("save after re-enable", int'(first >= 0), 1);
        wait_idle("re-enable");
        check("dirty after autosave", int'(bk_dirty), 0);
        autosave_en = 1'b0;

        // Ack never arrives: abort after ACK_TMO cycles with bk_err.
        resp_en  = 1'b0;
        ram_mask = 24'h0;
        trigger(OP_SAVE);
        check("timeout wr start", int'(sd_wr), 1);
        seen = 0;
        while (sd_wr && seen < 100) begin
            @(negedge clk_sys);
            seen++;
        end
        check("timeout cycles", seen, ACK_TMO);
        check("timeout err", int'(bk_err), 1);
        check("timeout busy", int'(bk_busy), 0);
        resp_en = 1'b1;
        run_op("after timeout", OP_SAVE, 24'h3FF, 2);

        for (int i = 0; i < 10; i++) begin
            int          op;
            logic [23:0] m;
            op      = $urandom_range(0, 2);
            m       = 24'($urandom_range(0, 24'h1FFF));
            dly_max = $urandom_range(0, 6);
            run_op($sformatf("rand%0d", i), op, m, model_blocks(m));
        end

        // Reset in the middle of a save at block 2.
        resp_en  = 1'b0;
        ram_mask = 24'h7FF;
        trigger(OP_SAVE);
        for (int b = 0; b < 2; b++) begin
            wait_wr_lba(b, ok);
            check($sformatf("manual req %0d", b), int'(ok), 1);
            man_ack = 1'b1;
            @(negedge clk_sys);
            man_ack = 1'b0;
            @(negedge clk_sys);
        end
        wait_wr_lba(2, ok);
        check("manual req 2", int'(ok), 1);
        reset = 1'b0;
        @(negedge clk_sys);
        check("mid reset outputs",
              int'({sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err}), 0);
        check("mid reset lba", int'(sd_lba), 0);
        reset = 1'b1;
        @(negedge clk_sys);
        resp_en = 1'b1;
        run_op("remount", OP_DL, 24'h7FF, 4);
        run_op("restart save", OP_SAVE, 24'h7FF, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
